// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read/1-write general-purpose register file.
// Default geometry: 64-bit data, 5-bit address (32 entries), zero register XZR at 31.
package regfile_pkg;

    localparam int unsigned REGFILE_N = 64;
    localparam int unsigned REGFILE_A = 5;
    localparam int unsigned XZR_IDX   = 31;

    typedef logic [REGFILE_A-1:0] reg_addr_t;
    typedef logic [REGFILE_N-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One read port of the register file: zero-register / write-bypass / storage
// select in that priority, followed by an optional output register.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   ra           : read address
//   we, wa, wd   : write port of the same cycle (for bypass)
//   mem          : storage array contents
//   rd           : read data (combinational or registered per REG_RD)
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned N        = REGFILE_N,
    parameter int unsigned A        = REGFILE_A,
    parameter bit          ZERO_EN  = 1'b1,
    parameter int unsigned ZERO_IDX = XZR_IDX,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          REG_RD   = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [A-1:0] ra,
    input  logic         we,
    input  logic [A-1:0] wa,
    input  logic [N-1:0] wd,
    input  logic [N-1:0] mem [2**A],
    output logic [N-1:0] rd
);

    logic [N-1:0] rd_sel_c;

    // Zero register wins over bypass, bypass wins over storage.
    always_comb begin
        rd_sel_c = mem[ra];
        if (BYPASS && we && (wa == ra)) begin
            rd_sel_c = wd;
        end
        if (ZERO_EN && (ra == A'(ZERO_IDX))) begin
            rd_sel_c = '0;
        end
    end

    generate
        if (REG_RD) begin : g_reg_rd
            logic [N-1:0] rd_d;
            logic [N-1:0] rd_q;

            always_comb begin
                rd_d = rd_sel_c;
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_d;
                end
            end

            assign rd = rd_q;
        end else begin : g_comb_rd
            // Clock and reset have no load in the combinational read mode.
            logic unused_clk_rst;
            assign unused_clk_rst = clock ^ reset;
            assign rd = rd_sel_c;
        end
    endgenerate

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised general-purpose register file: one synchronous write port,
// two independent read ports, optional hardwired zero register, optional
// same-cycle write-to-read bypass, combinational or registered reads.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset (clears all entries)
//   we, wa, wd   : write enable, address, data
//   ra_a, ra_b   : read addresses for ports A and B
//   rd_a, rd_b   : read data for ports A and B
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int unsigned N        = REGFILE_N,
    parameter int unsigned A        = REGFILE_A,
    parameter bit          ZERO_EN  = 1'b1,
    parameter int unsigned ZERO_IDX = XZR_IDX,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          REG_RD   = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         we,
    input  logic [A-1:0] wa,
    input  logic [N-1:0] wd,
    input  logic [A-1:0] ra_a,
    input  logic [A-1:0] ra_b,
    output logic [N-1:0] rd_a,
    output logic [N-1:0] rd_b
);

    localparam int unsigned DEPTH = 2**A;

    logic [N-1:0] mem_d [DEPTH];
    logic [N-1:0] mem_q [DEPTH];

    // Write logic: writes to the hardwired zero register are discarded.
    always_comb begin
        mem_d = mem_q;
        if (we && !(ZERO_EN && (wa == A'(ZERO_IDX)))) begin
            mem_d[wa] = wd;
        end
    end

    // Storage array; a write coinciding with reset is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_read_port #(
        .N        (N),
        .A        (A),
        .ZERO_EN  (ZERO_EN),
        .ZERO_IDX (ZERO_IDX),
        .BYPASS   (BYPASS),
        .REG_RD   (REG_RD)
    ) u_port_a (
        .clock (clock),
        .reset (reset),
        .ra    (ra_a),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .mem   (mem_q),
        .rd    (rd_a)
    );

    regfile_read_port #(
        .N        (N),
        .A        (A),
        .ZERO_EN  (ZERO_EN),
        .ZERO_IDX (ZERO_IDX),
        .BYPASS   (BYPASS),
        .REG_RD   (REG_RD)
    ) u_port_b (
        .clock (clock),
        .reset (reset),
        .ra    (ra_b),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .mem   (mem_q),
        .rd    (rd_b)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w. Four configurations share one stimulus:
//   k=0 default (comb read, bypass, XZR=31)
//   k=1 registered read
//   k=2 registered read, no zero register, no bypass
//   k=3 N=32, A=4, zero register at 0, comb read
module tb_regfile_2r1w;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic [4:0]  wa    = '0;
    logic [63:0] wd    = '0;
    logic [4:0]  ra_a  = '0;
    logic [4:0]  ra_b  = '0;
    logic        started = 1'b0;

    logic [63:0] rd_a0, rd_b0, rd_a1, rd_b1, rd_a2, rd_b2;
    logic [31:0] rd_a3, rd_b3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_2r1w u0 (
        .clock(clock), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a0), .rd_b(rd_b0)
    );

    regfile_2r1w #(.REG_RD(1'b1)) u1 (
        .clock(clock), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a1), .rd_b(rd_b1)
    );

    regfile_2r1w #(.ZERO_EN(1'b0), .BYPASS(1'b0), .REG_RD(1'b1)) u2 (
        .clock(clock), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a2), .rd_b(rd_b2)
    );

    regfile_2r1w #(.N(32), .A(4), .ZERO_IDX(0)) u3 (
        .clock(clock), .reset(reset), .we(we), .wa(wa[3:0]), .wd(wd[31:0]),
        .ra_a(ra_a[3:0]), .ra_b(ra_b[3:0]), .rd_a(rd_a3), .rd_b(rd_b3)
    );

    // ---------------- behavioural model ----------------
    logic [63:0] mdl_mem [4][32];
    logic [63:0] mdl_q   [4][2];

    function automatic logic [4:0] amask(input int k, input logic [4:0] a);
        return (k == 3) ? (a & 5'h0F) : a;
    endfunction

    function automatic logic [63:0] dmask(input int k, input logic [63:0] d);
        return (k == 3) ? {32'h0, d[31:0]} : d;
    endfunction

    function automatic bit has_zero(input int k);
        return k != 2;
    endfunction

    function automatic logic [4:0] zero_at(input int k);
        return (k == 3) ? 5'd0 : 5'd31;
    endfunction

    function automatic bit has_byp(input int k);
        return k != 2;
    endfunction

    function automatic bit is_reg(input int k);
        return (k == 1) || (k == 2);
    endfunction

    // Value a port of config k must deliver for address ra under current inputs.
    function automatic logic [63:0] rv(input int k, input logic [4:0] ra);
        logic [4:0] r;
        r = amask(k, ra);
        if (has_zero(k) && r == zero_at(k)) return 64'h0;
        if (has_byp(k) && we && amask(k, wa) == r) return dmask(k, wd);
        return mdl_mem[k][r];
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                for (int e = 0; e < 32; e++) mdl_mem[k][e] = 64'h0;
                mdl_q[k][0] = 64'h0;
                mdl_q[k][1] = 64'h0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                mdl_q[k][0] = rv(k, ra_a);
                mdl_q[k][1] = rv(k, ra_b);
            end
            for (int k = 0; k < 4; k++) begin
                if (we && !(has_zero(k) && amask(k, wa) == zero_at(k)))
                    mdl_mem[k][amask(k, wa)] = dmask(k, wd);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_out(input int k, input int p);
        case (k)
            0:       return p ? rd_b0 : rd_a0;
            1:       return p ? rd_b1 : rd_a1;
            2:       return p ? rd_b2 : rd_a2;
            default: return p ? {32'h0, rd_b3} : {32'h0, rd_a3};
        endcase
    endfunction

    // Every cycle out of reset: all eight outputs against the model.
    always @(negedge clock) begin
        if (started && !reset) begin
            for (int k = 0; k < 4; k++) begin
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("model k%0d p%0d", k, p), dut_out(k, p),
                        is_reg(k) ? mdl_q[k][p] : rv(k, p ? ra_b : ra_a));
                end
            end
        end
    end

    task automatic cyc(input logic w, input logic [4:0] a, input logic [63:0] d,
                       input logic [4:0] x, input logic [4:0] y);
        we = w; wa = a; wd = d; ra_a = x; ra_b = y;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        started = 1'b1;

        // Reset state
        cyc(0, 0, 0, 0, 5);
        chk("reset rd_a0", rd_a0, 64'h0);
        chk("reset rd_b1", rd_b1, 64'h0);

        // Write / read
        cyc(1, 5, 64'h0123_4567_89AB_CDEF, 0, 0);
        cyc(1, 30, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        cyc(0, 0, 0, 5, 30);
        chk("wr rd_a0", rd_a0, 64'h0123_4567_89AB_CDEF);
        chk("wr rd_b0", rd_b0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wr rd_a1", rd_a1, 64'h0123_4567_89AB_CDEF);
        chk("wr rd_b1", rd_b1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wr rd_a3", {32'h0, rd_a3}, 64'h89AB_CDEF);
        chk("wr rd_b3", {32'h0, rd_b3}, 64'hFFFF_FFFF);

        // Zero register
        cyc(1, 31, 64'hDEAD_BEEF_DEAD_BEEF, 31, 31);
        chk("xzr rd_a0 c0", rd_a0, 64'h0);
        chk("xzr rd_a1 c0", rd_a1, 64'h0);
        chk("nozero rd_a2 c0", rd_a2, 64'h0);
        cyc(0, 0, 0, 31, 31);
        chk("xzr rd_a0 c1", rd_a0, 64'h0);
        chk("xzr rd_a1 c1", rd_a1, 64'h0);
        chk("nozero rd_a2 c1", rd_a2, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("small e15 rd_a3", {32'h0, rd_a3}, 64'hDEAD_BEEF);

        // Bypass
        cyc(1, 7, 64'h11, 0, 0);
        we = 1'b1; wa = 5'd7; wd = 64'h22; ra_a = 5'd7; ra_b = 5'd7;
        #2;
        chk("byp rd_a0", rd_a0, 64'h22);
        chk("byp rd_b0", rd_b0, 64'h22);
        chk("byp rd_a3", {32'h0, rd_a3}, 64'h22);
        @(posedge clock);
        #1;
        chk("byp rd_a1", rd_a1, 64'h22);
        chk("byp rd_b1", rd_b1, 64'h22);
        chk("nobyp rd_a2", rd_a2, 64'h11);
        cyc(0, 0, 0, 7, 7);
        chk("nobyp rd_b2 next", rd_b2, 64'h22);

        // Small config: entry 0 hardwired (address 16 aliases to 0 there)
        we = 1'b1; wa = 5'd16; wd = 64'hABCD; ra_a = 5'd16; ra_b = 5'd0;
        #2;
        chk("small zero rd_a3", {32'h0, rd_a3}, 64'h0);
        chk("byp16 rd_a0", rd_a0, 64'hABCD);
        @(posedge clock);
        #1;

        // Back-to-back writes with opposite read sweeps
        for (int i = 0; i < 32; i++) begin
            cyc(1, 5'(i), 64'(i) * 64'h0101_0101, 5'(i), 5'(31 - i));
        end
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 0, 5'(i), 5'(31 - i));
        end
        chk("sweep rd_b0 e0", rd_b0, 64'h0);
        chk("sweep rd_a0 e31", rd_a0, 64'h0);
        chk("sweep rd_a2 e31", rd_a2, 64'h1F1F_1F1F);

        // Asynchronous reset mid-write
        we = 1'b1; wa = 5'd3; wd = 64'h3333; ra_a = 5'd5; ra_b = 5'd30;
        #2;
        reset = 1'b1;
        #1;
        chk("areset rd_a0", rd_a0, 64'h0);
        chk("areset rd_b1", rd_b1, 64'h0);
        chk("areset rd_a2", rd_a2, 64'h0);
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra_a = 5'(i);
            ra_b = 5'(31 - i);
            #1;
            chk("rst sweep rd_a0", rd_a0, 64'h0);
            chk("rst sweep rd_b0", rd_b0, 64'h0);
            chk("rst sweep rd_a3", {32'h0, rd_a3}, 64'h0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(0, 0, 0, 3, 5);
        chk("dropped wr rd_a1", rd_a1, 64'h0);
        chk("cleared rd_b1", rd_b1, 64'h0);
        cyc(1, 9, 64'h99, 9, 9);
        chk("first wr rd_a1", rd_a1, 64'h99);
        cyc(0, 0, 0, 9, 9);
        chk("first wr rd_a2", rd_a2, 64'h99);
        chk("first wr rd_b0", rd_b0, 64'h99);

        started = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
